// File: rtl/esm_rx_ctrl_report.sv
// ESM receiver front-end: config stream parser, AD9361 control, I/Q power windows, 8-word reports.
// Optional build macro ESM_RX_SEQ_CHECK_EN: count config sequence gaps into report w7[7:0].
module esm_rx_ctrl_report #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned ADC_WIDTH      = 16,
    parameter int unsigned IQ_WIDTH       = 12,
    parameter int unsigned REPORT_SAMPLES = 1024,
    parameter logic [31:0] CFG_MAGIC      = 32'h45534D43,
    parameter logic [31:0] RPT_MAGIC      = 32'h45534D52
) (
    input  logic                      Clk,
    input  logic                      Resetn,
    output logic [3:0]                Ad9361_control,
    input  logic [7:0]                Ad9361_status,
    input  logic                      Adc_valid,
    input  logic [ADC_WIDTH-1:0]      Adc_data_i,
    input  logic [ADC_WIDTH-1:0]      Adc_data_q,
    input  logic                      S_axis_valid,
    output logic                      S_axis_ready,
    input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
    input  logic                      S_axis_last,
    output logic                      M_axis_valid,
    input  logic                      M_axis_ready,
    output logic [AXI_DATA_WIDTH-1:0] M_axis_data,
    output logic                      M_axis_last
);
    localparam int unsigned CntW = $clog2(REPORT_SAMPLES + 1);
    localparam int unsigned PwrW = 2 * IQ_WIDTH;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    logic                    s_ready_q, magic_ok_q, hdr_ok_q, report_enable_q;
    logic [2:0]              cfg_idx_q;
    logic [31:0]             cfg_seq_q, payload_q, last_cfg_seq_q, cfg_payload;
    logic [3:0]              ctrl_q;
    logic [7:0]              drop_cnt_q, rpt_drop_q, low_byte;
    logic                    cfg_beat, cfg_done, cfg_ok, apply, drop, soft_rst;
    logic [63:0]             pwr_acc_q;
    logic [CntW-1:0]         sample_cnt_q;
    logic                    win_done_q, sample_take, snap_take, snap_drop;
    logic signed [IQ_WIDTH-1:0] iq_i, iq_q;
    logic signed [PwrW-1:0]  sq_i, sq_q;
    logic [PwrW:0]           pwr_sample;
    state_e                  state_q, state_d;
    logic [2:0]              word_q;
    logic [31:0]             rpt_seq_q, snap_cnt_q, snap_cfg_seq_q, snap_w7_q;
    logic [63:0]             snap_pwr_q;
    logic                    unused_bits;

    assign S_axis_ready   = s_ready_q;
    assign Ad9361_control = ctrl_q;

    assign cfg_beat    = S_axis_valid & s_ready_q;
    assign cfg_done    = cfg_beat & S_axis_last;
    assign cfg_ok      = magic_ok_q & hdr_ok_q & (cfg_idx_q >= 3'd4);
    // A 5-word packet closes on w4, so the payload is still on the bus.
    assign cfg_payload = (cfg_idx_q == 3'd4) ? S_axis_data : payload_q;
    assign apply       = cfg_done & cfg_ok;
    assign drop        = cfg_done & ~cfg_ok;
    assign soft_rst    = apply & cfg_payload[24];

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            s_ready_q       <= 1'b0;
            cfg_idx_q       <= 3'd0;
            magic_ok_q      <= 1'b0;
            hdr_ok_q        <= 1'b0;
            cfg_seq_q       <= 32'h0;
            payload_q       <= 32'h0;
            report_enable_q <= 1'b0;
            ctrl_q          <= 4'h0;
            last_cfg_seq_q  <= 32'h0;
            drop_cnt_q      <= 8'h0;
        end else begin
            s_ready_q <= 1'b1;
            if (cfg_beat) begin
                if (S_axis_last) cfg_idx_q <= 3'd0;
                else if (cfg_idx_q != 3'd7) cfg_idx_q <= cfg_idx_q + 3'd1;
                case (cfg_idx_q)
                    3'd0:    magic_ok_q <= (S_axis_data == CFG_MAGIC);
                    3'd1:    cfg_seq_q  <= S_axis_data;
                    3'd2:    hdr_ok_q   <= (S_axis_data[31:16] == 16'h0);
                    3'd4:    payload_q  <= S_axis_data;
                    default: ;
                endcase
            end
            if (apply) begin
                report_enable_q <= cfg_payload[0];
                ctrl_q          <= cfg_payload[11:8];
                last_cfg_seq_q  <= cfg_seq_q;
            end
            if (soft_rst) drop_cnt_q <= 8'h0;
            else if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'h1;
        end
    end

`ifdef ESM_RX_SEQ_CHECK_EN
    logic       seq_seen_q;
    logic [7:0] seq_err_q;
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            seq_seen_q <= 1'b0;
            seq_err_q  <= 8'h0;
        end else begin
            if (apply) seq_seen_q <= 1'b1;
            if (soft_rst) seq_err_q <= 8'h0;
            else if (apply && seq_seen_q && cfg_seq_q != last_cfg_seq_q + 32'h1 &&
                     seq_err_q != 8'hFF) seq_err_q <= seq_err_q + 8'h1;
        end
    end
    assign low_byte = seq_err_q;
`else
    assign low_byte = drop_cnt_q;
`endif

    assign iq_i        = Adc_data_i[ADC_WIDTH-1 -: IQ_WIDTH];
    assign iq_q        = Adc_data_q[ADC_WIDTH-1 -: IQ_WIDTH];
    assign sq_i        = PwrW'(iq_i) * PwrW'(iq_i);
    assign sq_q        = PwrW'(iq_q) * PwrW'(iq_q);
    assign pwr_sample  = {1'b0, sq_i} + {1'b0, sq_q};
    assign sample_take = Adc_valid & report_enable_q;
    assign snap_take   = win_done_q & (state_q == StIdle);
    assign snap_drop   = win_done_q & (state_q == StSend);

    // The snapshot cycle clears the window; a sample landing in it opens the next one.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            pwr_acc_q    <= 64'h0;
            sample_cnt_q <= '0;
            win_done_q   <= 1'b0;
        end else if (soft_rst) begin
            pwr_acc_q    <= 64'h0;
            sample_cnt_q <= '0;
            win_done_q   <= 1'b0;
        end else if (win_done_q) begin
            pwr_acc_q    <= sample_take ? 64'(pwr_sample) : 64'h0;
            sample_cnt_q <= sample_take ? CntW'(1) : '0;
            win_done_q   <= 1'b0;
        end else if (sample_take) begin
            pwr_acc_q    <= pwr_acc_q + 64'(pwr_sample);
            sample_cnt_q <= sample_cnt_q + CntW'(1);
            win_done_q   <= (sample_cnt_q == CntW'(REPORT_SAMPLES - 1));
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            word_q         <= 3'd0;
            rpt_seq_q      <= 32'h0;
            rpt_drop_q     <= 8'h0;
            snap_cnt_q     <= 32'h0;
            snap_pwr_q     <= 64'h0;
            snap_cfg_seq_q <= 32'h0;
            snap_w7_q      <= 32'h0;
        end else begin
            if (state_q == StSend && M_axis_ready) word_q <= word_q + 3'd1;
            if (M_axis_valid && M_axis_ready && M_axis_last) rpt_seq_q <= rpt_seq_q + 32'h1;
            if (snap_drop && rpt_drop_q != 8'hFF) rpt_drop_q <= rpt_drop_q + 8'h1;
            if (snap_take) begin
                snap_cnt_q     <= 32'(sample_cnt_q);
                snap_pwr_q     <= pwr_acc_q;
                snap_cfg_seq_q <= last_cfg_seq_q;
                snap_w7_q      <= {Ad9361_status, 4'h0, ctrl_q, rpt_drop_q, low_byte};
            end
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (snap_take) state_d = StSend;
            StSend:  if (M_axis_ready && word_q == 3'd7) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        M_axis_valid = (state_q == StSend);
        M_axis_last  = M_axis_valid && (word_q == 3'd7);
        M_axis_data  = '0;
        if (M_axis_valid) begin
            case (word_q)
                3'd0:    M_axis_data = RPT_MAGIC;
                3'd1:    M_axis_data = rpt_seq_q;
                3'd2:    M_axis_data = 32'h00100000;
                3'd3:    M_axis_data = snap_cfg_seq_q;
                3'd4:    M_axis_data = snap_cnt_q;
                3'd5:    M_axis_data = snap_pwr_q[31:0];
                3'd6:    M_axis_data = snap_pwr_q[63:32];
                default: M_axis_data = snap_w7_q;
            endcase
        end
    end

    assign unused_bits = ^{cfg_payload[31:25], cfg_payload[23:12], cfg_payload[7:1],
                           Adc_data_i[ADC_WIDTH-IQ_WIDTH-1:0], Adc_data_q[ADC_WIDTH-IQ_WIDTH-1:0]};
endmodule

// File: tb/tb_esm_rx_ctrl_report.sv
// Directed bench for esm_rx_ctrl_report: config parsing, power windows, report stream, resets.
// Expected report words are queued when stimulus is driven and popped as beats arrive.
module tb_esm_rx_ctrl_report;
    localparam logic [31:0] CFG_MAGIC = 32'h45534D43;
    localparam logic [31:0] RPT_MAGIC = 32'h45534D52;

    logic        Clk = 1'b0;
    logic        Resetn;
    logic [3:0]  Ad9361_control;
    logic [7:0]  Ad9361_status = 8'hA5;
    logic        Adc_valid = 1'b0;
    logic [15:0] Adc_data_i = 16'h0, Adc_data_q = 16'h0;
    logic        S_axis_valid = 1'b0, S_axis_ready, S_axis_last = 1'b0;
    logic [31:0] S_axis_data = 32'h0;
    logic        M_axis_valid, M_axis_ready = 1'b0, M_axis_last;
    logic [31:0] M_axis_data;

    logic [31:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    esm_rx_ctrl_report dut (
        .Clk(Clk), .Resetn(Resetn), .Ad9361_control(Ad9361_control),
        .Ad9361_status(Ad9361_status), .Adc_valid(Adc_valid),
        .Adc_data_i(Adc_data_i), .Adc_data_q(Adc_data_q),
        .S_axis_valid(S_axis_valid), .S_axis_ready(S_axis_ready),
        .S_axis_data(S_axis_data), .S_axis_last(S_axis_last),
        .M_axis_valid(M_axis_valid), .M_axis_ready(M_axis_ready),
        .M_axis_data(M_axis_data), .M_axis_last(M_axis_last)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w7(input logic [7:0] st, input logic [3:0] ctrl,
                                       input logic [7:0] rdrop, input logic [7:0] drop);
`ifdef ESM_RX_SEQ_CHECK_EN
        return {st, 4'h0, ctrl, rdrop, 8'h00};  // stimulus never skips a sequence number
`else
        return {st, 4'h0, ctrl, rdrop, drop};
`endif
    endfunction

    task automatic cfg_word(input logic [31:0] d, input logic l);
        int g = 0;
        S_axis_valid = 1'b1;
        S_axis_data  = d;
        S_axis_last  = l;
        while (S_axis_ready !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        check("cfg_ready", S_axis_ready, 1);
        step();
        S_axis_valid = 1'b0;
        S_axis_last  = 1'b0;
    endtask

    task automatic cfg_msg(input logic [31:0] seq, input logic [31:0] payload);
        cfg_word(CFG_MAGIC, 1'b0);
        cfg_word(seq, 1'b0);
        cfg_word(32'h0, 1'b0);
        cfg_word(32'hFFFF_FFFF, 1'b0);
        cfg_word(payload, 1'b0);
        cfg_word(32'h1234_5678, 1'b1);
    endtask

    task automatic samples(input int n, input logic [15:0] i, input logic [15:0] q);
        Adc_valid  = 1'b1;
        Adc_data_i = i;
        Adc_data_q = q;
        for (int k = 0; k < n; k++) step();
        Adc_valid = 1'b0;
    endtask

    task automatic push_report(input logic [31:0] seq, input logic [31:0] cfg_seq,
                               input logic [31:0] cnt, input logic [63:0] pwr,
                               input logic [31:0] last_word);
        sb.push_back(RPT_MAGIC);
        sb.push_back(seq);
        sb.push_back(32'h00100000);
        sb.push_back(cfg_seq);
        sb.push_back(cnt);
        sb.push_back(pwr[31:0]);
        sb.push_back(pwr[63:32]);
        sb.push_back(last_word);
    endtask

    task automatic recv_report(input bit rnd);
        int          w = 0;
        int          guard = 0;
        logic        prev_stalled = 1'b0;
        logic [31:0] prev_d = 32'h0;
        logic [31:0] exp;
        while (w < 8 && guard < 3000) begin
            M_axis_ready = rnd ? ($urandom_range(0, 99) < 80) : 1'b1;
            if (prev_stalled) begin
                check("stall_valid", M_axis_valid, 1);
                check("stall_data", M_axis_data, prev_d);
            end
            if (M_axis_valid && M_axis_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL sb_empty: observed beat %h expected none", M_axis_data);
                end else begin
                    exp = sb.pop_front();
                    check($sformatf("rpt_w%0d", w), M_axis_data, exp);
                end
                check("rpt_last", M_axis_last, (w == 7));
                w++;
            end
            prev_stalled = M_axis_valid && !M_axis_ready;
            prev_d       = M_axis_data;
            step();
            guard++;
        end
        M_axis_ready = 1'b0;
        if (w < 8) begin
            n_cmp++;
            n_err++;
            $error("FAIL rpt_timeout: observed %0d words expected 8", w);
        end
    endtask

    initial begin
        int g;
        // Reset state
        Resetn = 1'b1;
        #2 Resetn = 1'b0;
        #1;
        check("rst_s_ready", S_axis_ready, 0);
        check("rst_m_valid", M_axis_valid, 0);
        check("rst_m_data", M_axis_data, 0);
        check("rst_m_last", M_axis_last, 0);
        check("rst_ctrl", Ad9361_control, 0);
        repeat (3) @(posedge Clk);
        #3 Resetn = 1'b1;
        step();
        check("s_ready_after_rst", S_axis_ready, 1);

        // Control message enables reporting, AD9361 control = 3
        cfg_msg(32'd0, 32'h0000_0301);
        check("ctrl_3", Ad9361_control, 4'h3);
        push_report(0, 0, 1024, 64'd2048, w7(8'hA5, 4'h3, 8'h0, 8'h0));
        samples(1024, 16'h0010, 16'h0010);
        recv_report(1'b0);

        // Bad magic is dropped; then control 5, status changes, mixed-sign samples
        cfg_word(32'hDEAD_BEEF, 1'b0);
        for (int k = 0; k < 4; k++) cfg_word(32'h0, 1'b0);
        cfg_word(32'h0000_0301, 1'b1);
        check("ctrl_after_bad", Ad9361_control, 4'h3);
        cfg_msg(32'd1, 32'h0000_0501);
        check("ctrl_5", Ad9361_control, 4'h5);
        Ad9361_status = 8'h3C;
        push_report(1, 1, 1024, 64'd5120, w7(8'h3C, 4'h5, 8'h0, 8'h1));  // (2^2 + 1) * 1024
        samples(1024, 16'h0020, 16'hFFF0);
        recv_report(1'b0);

        // Window A stalls on the stream while window B closes: B dropped
        push_report(2, 1, 1024, 64'd2048, w7(8'h3C, 4'h5, 8'h0, 8'h1));
        samples(1024, 16'h0010, 16'h0010);
        samples(1024, 16'h0040, 16'h0040);
        recv_report(1'b1);
        push_report(3, 1, 1024, 64'd18432, w7(8'h3C, 4'h5, 8'h1, 8'h1));  // 18 * 1024
        samples(1024, 16'h0030, 16'h0030);
        recv_report(1'b1);

        // Soft reset mid-window: partial window discarded, reporting disabled
        samples(500, 16'h0030, 16'h0030);
        cfg_msg(32'd2, 32'h0100_0000);
        check("ctrl_soft", Ad9361_control, 4'h0);
        samples(1024, 16'h0030, 16'h0030);
        check("no_rpt_disabled", M_axis_valid, 0);
        cfg_msg(32'd3, 32'h0000_0301);
        check("ctrl_reenable", Ad9361_control, 4'h3);
        push_report(4, 3, 1024, 64'd2048, w7(8'h3C, 4'h3, 8'h1, 8'h0));
        samples(1024, 16'h0010, 16'h0010);
        recv_report(1'b0);

        // Async reset in the middle of a report
        samples(1024, 16'h0010, 16'h0010);
        g = 0;
        while (!M_axis_valid && g < 20) begin
            step();
            g++;
        end
        check("pre_rst_valid", M_axis_valid, 1);
        M_axis_ready = 1'b1;
        repeat (3) step();
        M_axis_ready = 1'b0;
        check("pre_rst_word3", M_axis_data, 32'd3);
        #2 Resetn = 1'b0;
        #1;
        check("midrst_valid", M_axis_valid, 0);
        check("midrst_last", M_axis_last, 0);
        check("midrst_ready", S_axis_ready, 0);
        check("midrst_ctrl", Ad9361_control, 0);
        repeat (2) @(posedge Clk);
        #3 Resetn = 1'b1;
        step();
        check("post_rst_ready", S_axis_ready, 1);
        check("post_rst_valid", M_axis_valid, 0);
        cfg_msg(32'd0, 32'h0000_0301);
        push_report(0, 0, 1024, 64'd2048, w7(8'h3C, 4'h3, 8'h0, 8'h0));
        samples(1024, 16'h0010, 16'h0010);
        recv_report(1'b1);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
